// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 interrupt-acknowledge sequencer.
package pic_pkg;

   localparam int unsigned NUM_IRQ       = 8;
   localparam int unsigned IDX_W         = 3;
   localparam int unsigned VECTOR_BASE_W = 5;
   localparam int unsigned VECTOR_W      = VECTOR_BASE_W + IDX_W;

   localparam logic [IDX_W-1:0] SPURIOUS_IDX   = IDX_W'(7);
   localparam logic [IDX_W-1:0] LOWEST_PTR_RST = IDX_W'(7);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK2_WAIT,
      ST_ACK2
   } state_e;

   typedef struct packed {
      logic [VECTOR_BASE_W-1:0] base;
      logic [IDX_W-1:0]         idx;
   } vector_t;

   // Priority rank of an IR level: 0 is highest (the level just after lowest_ptr).
   function automatic logic [IDX_W-1:0] prio_rank(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] lowest_ptr);
      return idx - lowest_ptr - IDX_W'(1);
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority search: first set request after lowest_ptr, moving upward modulo NUM_IRQ.
module pic_priority_resolver
   import pic_pkg::*;
(
   input  logic [NUM_IRQ-1:0] req,
   input  logic [IDX_W-1:0]   lowest_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   always_comb begin
      logic [IDX_W-1:0] k;
      valid = 1'b0;
      idx   = '0;
      k     = '0;
      for (int unsigned i = 1; i <= NUM_IRQ; i++) begin
         k = lowest_ptr + IDX_W'(i);
         if (!valid && req[k]) begin
            valid = 1'b1;
            idx   = k;
         end
      end
   end

endmodule

// File: rtl/pic_ack_controller.sv
// 8259 INT/INTA sequencer: priority resolution, ISR ownership, vector drive and EOI handling.
// Optional PIC_AUTO_ROTATE_EN compiles in the rotating lowest-priority pointer.
module pic_ack_controller
   import pic_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IRQ-1:0]       irr,
   input  logic [NUM_IRQ-1:0]       imr,
   input  logic                     inta_n,
   input  logic                     aeoi,
   input  logic                     eoi_cmd,
   input  logic                     specific_eoi,
   input  logic [IDX_W-1:0]         eoi_level,
   input  logic                     rotate_on_eoi,
   input  logic [VECTOR_BASE_W-1:0] vector_base,
   output logic                     int_out,
   output logic [NUM_IRQ-1:0]       isr,
   output logic [NUM_IRQ-1:0]       irr_clear,
   output logic [VECTOR_W-1:0]      data_out,
   output logic                     data_oe,
   output logic [IDX_W-1:0]         last_eoi_idx
);

   state_e               state_q, state_d;
   logic                 inta_prev_q, inta_prev_d;
   logic                 int_q, int_d;
   logic [NUM_IRQ-1:0]   isr_q, isr_d;
   logic [NUM_IRQ-1:0]   irr_clear_q, irr_clear_d;
   vector_t              data_out_q, data_out_d;
   logic                 data_oe_q, data_oe_d;
   logic [IDX_W-1:0]     last_eoi_q, last_eoi_d;
   logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
   logic                 spurious_q, spurious_d;
   logic [IDX_W-1:0]     lowest_ptr_q;

   logic                 inta_fall_c, inta_rise_c;
   logic [NUM_IRQ-1:0]   cand_req_c;
   logic                 cand_valid_c, isr_valid_c;
   logic [IDX_W-1:0]     cand_idx_c, isr_idx_c;
   logic                 rotate_c;
   logic [IDX_W-1:0]     rotate_idx_c;

   assign inta_fall_c = inta_prev_q & ~inta_n;
   assign inta_rise_c = ~inta_prev_q & inta_n;

   // Fully nested: only requests strictly above the highest in-service level compete.
   always_comb begin
      cand_req_c = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (!isr_valid_c ||
             (prio_rank(IDX_W'(i), lowest_ptr_q) < prio_rank(isr_idx_c, lowest_ptr_q))) begin
            cand_req_c[i] = irr[i] & ~imr[i];
         end
      end
   end

   pic_priority_resolver u_cand_res (
      .req        (cand_req_c),
      .lowest_ptr (lowest_ptr_q),
      .valid      (cand_valid_c),
      .idx        (cand_idx_c)
   );

   pic_priority_resolver u_isr_res (
      .req        (isr_q),
      .lowest_ptr (lowest_ptr_q),
      .valid      (isr_valid_c),
      .idx        (isr_idx_c)
   );

`ifdef PIC_AUTO_ROTATE_EN
   logic [IDX_W-1:0] lowest_ptr_d;

   always_comb begin
      lowest_ptr_d = lowest_ptr_q;
      if (rotate_c) lowest_ptr_d = rotate_idx_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lowest_ptr_q <= LOWEST_PTR_RST;
      else     lowest_ptr_q <= lowest_ptr_d;
   end
`else
   logic unused_rotate;

   assign lowest_ptr_q  = LOWEST_PTR_RST;
   assign unused_rotate = ^{rotate_c, rotate_idx_c};
`endif

   // Next state and outputs; EOI clears are applied before any ISR set in the same cycle.
   always_comb begin
      state_d      = state_q;
      inta_prev_d  = inta_n;
      int_d        = int_q;
      isr_d        = isr_q;
      irr_clear_d  = '0;
      data_out_d   = data_out_q;
      data_oe_d    = data_oe_q;
      last_eoi_d   = last_eoi_q;
      cur_idx_d    = cur_idx_q;
      spurious_d   = spurious_q;
      rotate_c     = 1'b0;
      rotate_idx_c = lowest_ptr_q;

      if (eoi_cmd) begin
         if (specific_eoi) begin
            if (isr_q[eoi_level]) begin
               isr_d[eoi_level] = 1'b0;
               last_eoi_d       = eoi_level;
               rotate_c         = rotate_on_eoi;
               rotate_idx_c     = eoi_level;
            end
         end else if (isr_valid_c) begin
            isr_d[isr_idx_c] = 1'b0;
            last_eoi_d       = isr_idx_c;
            rotate_c         = rotate_on_eoi;
            rotate_idx_c     = isr_idx_c;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cand_valid_c) begin
               state_d = ST_REQ;
               int_d   = 1'b1;
            end
         end
         ST_REQ: begin
            if (inta_fall_c) begin
               state_d = ST_ACK2_WAIT;
               if (cand_valid_c) begin
                  cur_idx_d               = cand_idx_c;
                  spurious_d              = 1'b0;
                  isr_d[cand_idx_c]       = 1'b1;
                  irr_clear_d[cand_idx_c] = 1'b1;
               end else begin
                  cur_idx_d  = SPURIOUS_IDX;
                  spurious_d = 1'b1;
               end
            end
         end
         ST_ACK2_WAIT: begin
            if (inta_fall_c) begin
               state_d         = ST_ACK2;
               int_d           = 1'b0;
               data_out_d.base = vector_base;
               data_out_d.idx  = cur_idx_q;
               data_oe_d       = 1'b1;
            end
         end
         ST_ACK2: begin
            if (inta_rise_c) begin
               state_d   = ST_IDLE;
               data_oe_d = 1'b0;
               if (aeoi && !spurious_q) begin
                  isr_d[cur_idx_q] = 1'b0;
                  last_eoi_d       = cur_idx_q;
                  rotate_c         = rotate_on_eoi;
                  rotate_idx_c     = cur_idx_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         inta_prev_q <= 1'b1;
         int_q       <= 1'b0;
         isr_q       <= '0;
         irr_clear_q <= '0;
         data_out_q  <= '0;
         data_oe_q   <= 1'b0;
         last_eoi_q  <= '0;
         cur_idx_q   <= '0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         inta_prev_q <= inta_prev_d;
         int_q       <= int_d;
         isr_q       <= isr_d;
         irr_clear_q <= irr_clear_d;
         data_out_q  <= data_out_d;
         data_oe_q   <= data_oe_d;
         last_eoi_q  <= last_eoi_d;
         cur_idx_q   <= cur_idx_d;
         spurious_q  <= spurious_d;
      end
   end

   assign int_out      = int_q;
   assign isr          = isr_q;
   assign irr_clear    = irr_clear_q;
   assign data_out     = data_out_q;
   assign data_oe      = data_oe_q;
   assign last_eoi_idx = last_eoi_q;

endmodule

// File: tb/tb_pic_ack_controller.sv
// Randomized bench for pic_ack_controller against a transaction-level 8259 priority model.
module tb_pic_ack_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irr, imr;
   logic       inta_n, aeoi, eoi_cmd, specific_eoi, rotate_on_eoi;
   logic [2:0] eoi_level;
   logic [4:0] vector_base;
   logic       int_out, data_oe;
   logic [7:0] isr, irr_clear, data_out;
   logic [2:0] last_eoi_idx;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   logic [7:0] m_isr;
   int         m_lp;
   int         m_last;

   always #5 clk = ~clk;

   pic_ack_controller dut (
      .clk           (clk),
      .rst           (rst),
      .irr           (irr),
      .imr           (imr),
      .inta_n        (inta_n),
      .aeoi          (aeoi),
      .eoi_cmd       (eoi_cmd),
      .specific_eoi  (specific_eoi),
      .eoi_level     (eoi_level),
      .rotate_on_eoi (rotate_on_eoi),
      .vector_base   (vector_base),
      .int_out       (int_out),
      .isr           (isr),
      .irr_clear     (irr_clear),
      .data_out      (data_out),
      .data_oe       (data_oe),
      .last_eoi_idx  (last_eoi_idx)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Highest-priority set bit of v when lp is the lowest-priority level; -1 if none.
   function automatic int best(input logic [7:0] v, input int lp);
      for (int off = 1; off <= 8; off++) begin
         int k;
         k = (lp + off) % 8;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   function automatic int rank(input int k, input int lp);
      return (k - lp + 7) % 8;
   endfunction

   function automatic int model_cand(input logic [7:0] r, input logic [7:0] m);
      int h, c;
      h = best(m_isr, m_lp);
      c = best(r & ~m, m_lp);
      if (c < 0) return -1;
      if (h >= 0 && rank(c, m_lp) >= rank(h, m_lp)) return -1;
      return c;
   endfunction

   task automatic model_clear(input int idx, input bit rot);
      m_isr[idx] = 1'b0;
      m_last     = idx;
`ifdef PIC_AUTO_ROTATE_EN
      if (rot) m_lp = idx;
`else
      if (rot) m_lp = m_lp;
`endif
   endtask

   task automatic model_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
      int h;
      if (spec) begin
         if (m_isr[lvl]) model_clear(int'(lvl), rot);
      end else begin
         h = best(m_isr, m_lp);
         if (h >= 0) model_clear(h, rot);
      end
   endtask

   task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
      eoi_cmd       = 1'b1;
      specific_eoi  = spec;
      eoi_level     = lvl;
      rotate_on_eoi = rot;
      tick();
      eoi_cmd = 1'b0;
      model_eoi(spec, lvl, rot);
      check_eq("eoi_isr", 32'(isr), 32'(m_isr));
      check_eq("eoi_last", 32'(last_eoi_idx), 32'(m_last));
   endtask

   // One request/acknowledge transaction; returns early when no INT is expected.
   task automatic run_seq(input logic [7:0] r, input logic [7:0] m, input logic [4:0] vb,
                          input bit ae, input bit wd, input bit eo_same, input bit eo_spec,
                          input logic [2:0] eo_lvl, input bit eo_rot);
      int         c, ce;
      logic [2:0] vidx;
      irr           = r;
      imr           = m;
      vector_base   = vb;
      aeoi          = ae;
      rotate_on_eoi = eo_rot;
      c = model_cand(r, m);
      tick();
      check_eq("int_req", 32'(int_out), (c >= 0) ? 32'd1 : 32'd0);
      if (c < 0) begin
         irr = 8'h00;
         tick();
         return;
      end
      if (wd) irr = 8'h00;
      ce = wd ? -1 : c;
      inta_n = 1'b0;
      if (eo_same) begin
         eoi_cmd      = 1'b1;
         specific_eoi = eo_spec;
         eoi_level    = eo_lvl;
      end
      tick();
      eoi_cmd = 1'b0;
      if (eo_same) model_eoi(eo_spec, eo_lvl, eo_rot);
      if (ce >= 0) m_isr[ce] = 1'b1;
      check_eq("irr_clear", 32'(irr_clear), (ce >= 0) ? (32'd1 << ce) : 32'd0);
      check_eq("ack1_isr", 32'(isr), 32'(m_isr));
      check_eq("ack1_last", 32'(last_eoi_idx), 32'(m_last));
      irr = 8'h00;
      tick();
      check_eq("irr_clear_1cyc", 32'(irr_clear), 32'd0);
      inta_n = 1'b1;
      tick();
      inta_n = 1'b0;
      tick();
      vidx = (ce >= 0) ? 3'(ce) : 3'd7;
      check_eq("ack2_oe", 32'(data_oe), 32'd1);
      check_eq("ack2_vec", 32'(data_out), 32'({vb, vidx}));
      check_eq("ack2_int", 32'(int_out), 32'd0);
      inta_n = 1'b1;
      tick();
      if (ae && ce >= 0) model_clear(ce, eo_rot);
      check_eq("rise_oe", 32'(data_oe), 32'd0);
      check_eq("rise_isr", 32'(isr), 32'(m_isr));
      check_eq("rise_last", 32'(last_eoi_idx), 32'(m_last));
      tick();
   endtask

   initial begin
      rst = 1'b1; irr = '0; imr = '0; inta_n = 1'b1; aeoi = 1'b0; eoi_cmd = 1'b0;
      specific_eoi = 1'b0; eoi_level = '0; rotate_on_eoi = 1'b0; vector_base = '0;
      m_isr = '0; m_lp = 7; m_last = 0;
      tick(); tick();
      check_eq("rst_int", 32'(int_out), 32'd0);
      check_eq("rst_isr", 32'(isr), 32'd0);
      check_eq("rst_oe", 32'(data_oe), 32'd0);
      check_eq("rst_irr_clear", 32'(irr_clear), 32'd0);
      check_eq("rst_data", 32'(data_out), 32'd0);
      check_eq("rst_last", 32'(last_eoi_idx), 32'd0);
      rst = 1'b0;
      tick();

      // Basic acknowledge of IR2 with vector base 0x08
      run_seq(8'h24, 8'h00, 5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check_eq("t1_isr", 32'(isr), 32'h04);
      check_eq("t1_vec", 32'(data_out), 32'h42);
      do_eoi(1'b0, 3'd0, 1'b0);

      // Automatic EOI
      run_seq(8'h24, 8'h00, 5'h08, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check_eq("aeoi_isr", 32'(isr), 32'h00);
      check_eq("aeoi_last", 32'(last_eoi_idx), 32'd2);

      // Nesting: IR4 blocked behind IR3, IR1 preempts
      run_seq(8'h08, 8'h00, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      run_seq(8'h10, 8'h00, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check_eq("nest_block", 32'(isr), 32'h08);
      run_seq(8'h02, 8'h00, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check_eq("nest_preempt", 32'(isr), 32'h0a);
      do_eoi(1'b0, 3'd0, 1'b0);
      do_eoi(1'b0, 3'd0, 1'b0);

      // Spurious: request withdrawn before the first INTA
      run_seq(8'h01, 8'h00, 5'h11, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      check_eq("spur_vec", 32'(data_out), 32'h8f);
      check_eq("spur_isr", 32'(isr), 32'h00);

`ifdef PIC_AUTO_ROTATE_EN
      // Rotation on non-specific EOI makes IR3 lowest, so IR4 outranks IR2
      run_seq(8'h08, 8'h00, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      do_eoi(1'b0, 3'd0, 1'b1);
      run_seq(8'h14, 8'h00, 5'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check_eq("rot_ir4", 32'(last_eoi_idx), 32'd4);
`endif

      // Specific EOI on the same edge that sets the same level: set wins
      run_seq(8'h20, 8'h00, 5'h03, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
      check_eq("set_wins", 32'(isr[5]), 32'd1);
      do_eoi(1'b1, 3'd5, 1'b0);

      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 9) < 3) begin
            do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end else begin
            run_seq(8'($urandom & $urandom), 8'($urandom & $urandom & $urandom),
                    5'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end
      end

      // Asynchronous reset in the middle of an acknowledge
      do_eoi(1'b0, 3'd0, 1'b0);
      do_eoi(1'b0, 3'd0, 1'b0);
      irr = 8'hff; imr = 8'h00;
      tick();
      inta_n = 1'b0;
      tick();
      check_eq("mid_isr_set", 32'(isr != 8'h00), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("mid_rst_isr", 32'(isr), 32'd0);
      check_eq("mid_rst_int", 32'(int_out), 32'd0);
      check_eq("mid_rst_oe", 32'(data_oe), 32'd0);
      irr = 8'h00; inta_n = 1'b1;
      tick();
      rst = 1'b0;
      m_isr = '0; m_lp = 7; m_last = 0;
      tick();
      check_eq("post_rst_int", 32'(int_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pic_ack_controller.md
# pic_ack_controller

Clocked interrupt-acknowledge sequencer for the 8259 PIC core. It resolves priority between pending unmasked requests and asserts INT. It runs the two-pulse INTA handshake, setting and clearing in-service bits and driving the vector byte, and applies EOI commands with optional priority rotation. It owns the in-service register state and feeds the data-bus buffer and the IRR clear logic.

## Interface
- VECTOR_BASE_W, 5: width of the vector base field (T7–T3).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- irr  in  8  interrupt request register (level, already edge/level-conditioned upstream).
- imr  in  8  interrupt mask register; 1 = masked.
- inta_n  in  1  INTA strobe, active-low, already synchronized to clk.
- aeoi  in  1  1 = automatic EOI at end of second INTA.
- eoi_cmd  in  1  one-cycle pulse: an OCW2 EOI command has been written.
- specific_eoi  in  1  qualifies eoi_cmd: 1 = specific, 0 = non-specific.
- eoi_level  in  3  IR index for specific EOI.
- rotate_on_eoi  in  1  qualifies eoi_cmd/AEOI: 1 = cleared level becomes lowest priority.
- vector_base  in  5  T7–T3 of the vector.
- int_out  out  1  INT request to CPU.
- isr  out  8  in-service register.
- irr_clear  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
- data_out  out  8  vector byte {vector_base, idx}.
- data_oe  out  1  drive data_out onto the bus.
- last_eoi_idx  out  3  index most recently cleared from isr.

## Operation
- Priority order: the level after lowest_ptr is highest; the search proceeds upward modulo 8. lowest_ptr resets to 7, giving IR0 the highest priority.
- Candidate: the highest-priority bit of irr & ~imr whose priority is strictly above the highest set isr bit (fully nested). No candidate means INT is not requested.
- FSM states: IDLE, REQ, ACK2_WAIT, ACK2.
  - IDLE → REQ when a candidate exists; int_out=1.
  - REQ, first INTA falling edge: latch cur_idx = candidate.
    - Set isr[cur_idx] and pulse irr_clear[cur_idx]; go to ACK2_WAIT.
    - If no candidate exists at that edge (request withdrawn): spurious case. cur_idx=7, isr unchanged, no irr_clear.
  - ACK2_WAIT, second INTA falling edge: go to ACK2; int_out=0; data_out={vector_base,cur_idx}; data_oe=1.
  - ACK2, INTA rising edge: data_oe=0.
    - If aeoi and not spurious: clear isr[cur_idx]; last_eoi_idx=cur_idx; rotate if rotate_on_eoi.
    - Go to IDLE.
- EOI (eoi_cmd, any state):
  - Non-specific: clear the highest-priority set isr bit; no-op if isr==0.
  - Specific: clear isr[eoi_level].
  - Update last_eoi_idx only when a bit is cleared. If rotate_on_eoi, lowest_ptr = cleared index.
- Simultaneous eoi_cmd and an isr-set edge in the same cycle: apply the clear first, then the set. If both target the same bit, the set wins.
- irr/imr changes during REQ affect only the index latched at the first INTA edge.

## Timing
- Reset values: all outputs 0, lowest_ptr=7, state IDLE, inta_n history=1.
- INTA edges are detected from the registered previous inta_n. All outputs are registered and update in the cycle after the edge sample.
- int_out asserts 1 cycle after a candidate first appears in IDLE.
- irr_clear is exactly one cycle wide.
- data_oe is high from 1 cycle after the second falling edge until 1 cycle after the rising edge.
- Reset mid-sequence returns the FSM to IDLE and clears isr immediately (asynchronous).

## Configuration
- PIC_AUTO_ROTATE_EN defined: lowest_ptr register and rotate_on_eoi handling are compiled in.
- Undefined: lowest_ptr is the constant 7, rotate_on_eoi is ignored, and priority is fixed with IR0 highest.

## Structure
- pic_pkg: state enum, NUM_IRQ=8, IDX_W=3, SPURIOUS_IDX=7.
- pic_priority_resolver: combinational sub-module. Inputs are a request vector and lowest_ptr; outputs are valid and idx. Instantiated twice: once for the candidate search, once for the non-specific EOI/isr-highest search.

## Test plan
- irr=0x24, imr=0, two INTA pulses, vector_base=0x08, aeoi=0 → int_out=1, isr=0x04 after the first pulse, data_out=0x42, irr_clear=0x04.
- Same stimulus with aeoi=1 → isr returns to 0x00 after the second pulse rises; last_eoi_idx=2.
- isr=0x08, irr=0x10 → no int_out. Then irr=0x02 → int_out=1 (nested preemption).
- irr=0x01 withdrawn before the first INTA → data_out={base,3'd7}, isr unchanged (spurious).
- With PIC_AUTO_ROTATE_EN: isr=0x08, non-specific eoi_cmd with rotate_on_eoi=1 → isr=0x00, lowest_ptr=3. Then irr=0x14 → IR4 is serviced first.
- eoi_cmd specific eoi_level=5 on the same cycle as the first INTA edge selecting IR5 → isr[5]=1 (set wins).
